// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, state encoding and count limits for the ALU sequencer
package alu_seq_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   localparam int COUNT_W = 4;
   localparam logic [COUNT_W-1:0] COUNT_MAX = 4'd15;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_RESP  = 1'b1
   } seqStateT;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command and result handshakes of the ALU sequencer
interface alu_sequencer_if
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 4
);

   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [WIDTH-1:0]   cmd_data;
   logic               cmd_load;
   logic               cmd_last;

   logic               res_valid;
   logic               res_ready;
   logic [WIDTH-1:0]   res_data;
   logic               res_carry;
   logic [COUNT_W-1:0] res_count;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_load, cmd_last, res_ready,
      input  cmd_ready, res_valid, res_data, res_carry, res_count
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_load, cmd_last, res_ready,
      output cmd_ready, res_valid, res_data, res_carry, res_count
   );

endinterface

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - combinational AND/OR/XOR/ADD/load datapath with carry-out
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             load,
   output logic [WIDTH-1:0] y,
   output logic             cout
);

   logic [WIDTH:0] sum;

   always_comb begin
      y    = '0;
      cout = 1'b0;
      sum  = {1'b0, a} + {1'b0, b};
      if (load) begin
         y = b;
      end else begin
         case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_ADD: begin
               y    = sum[WIDTH-1:0];
               cout = sum[WIDTH];
            end
            default: begin
               y    = '0;
               cout = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command-driven accumulator presenting a result per command sequence
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   alu_sequencer_if.slave  bus
);

   seqStateT           state;
   seqStateT           nextState;
   logic [WIDTH-1:0]   acc;
   logic               carry;
   logic [COUNT_W-1:0] count;

   logic [WIDTH-1:0]   aluY;
   logic               aluCout;
   logic               cmdAccept;
   logic               resAccept;
   logic               isAdd;

   alu_seq_core #(.WIDTH(WIDTH)) core (
      .a    (acc),
      .b    (bus.cmd_data),
      .op   (bus.cmd_op),
      .load (bus.cmd_load),
      .y    (aluY),
      .cout (aluCout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_ACCUM;
      end else begin
         state <= nextState;
      end
   end

   // Handshake outputs depend only on state, so no cmd_* or res_ready path reaches them.
   always_comb begin
      nextState     = state;
      cmdAccept     = 1'b0;
      resAccept     = 1'b0;
      bus.cmd_ready = 1'b0;
      bus.res_valid = 1'b0;
      case (state)
         ST_ACCUM: begin
            bus.cmd_ready = 1'b1;
            cmdAccept     = bus.cmd_valid;
            if (bus.cmd_valid && bus.cmd_last) begin
               nextState = ST_RESP;
            end
         end
         ST_RESP: begin
            bus.res_valid = 1'b1;
            resAccept     = bus.res_ready;
            if (bus.res_ready) begin
               nextState = ST_ACCUM;
            end
         end
         default: begin
            nextState = ST_ACCUM;
         end
      endcase
   end

   assign isAdd = !bus.cmd_load && (bus.cmd_op == OP_ADD);

   always_ff @(posedge clk) begin
      if (reset || resAccept) begin
         acc   <= '0;
         carry <= 1'b0;
         count <= '0;
      end else if (cmdAccept) begin
         acc <= aluY;
         if (isAdd) begin
            carry <= carry | aluCout;
         end
         if (count != COUNT_MAX) begin
            count <= count + 1'b1;
         end
      end
   end

   assign bus.res_data  = acc;
   assign bus.res_carry = carry;
   assign bus.res_count = count;

endmodule
